memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- MEM stage of the five-stage pipeline, directly downstream of the ALU/EX stage.
- Consumes the EX/MEM bundle: ALU result as byte address or pass-through, rt store data, destination register and control bits.
- Performs word load/store into an internal data memory of 2^ADDRESS_WIDTH words with configurable access latency.
- Presents a registered MEM/WB bundle to write-back and stalls upstream while a multi-cycle access is in flight.

Parameters:
ADDRESS_WIDTH, 10, word-address bits; memory depth = 2^ADDRESS_WIDTH 32-bit words
MEMORY_LATENCY, 2, cycles from accept edge to result for aligned memory ops; legal range >= 1

Ports:
system_clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
ex_valid  input  1  EX/MEM bundle valid this cycle
alu_result  input  32  byte address for memory ops, else result to write back
store_data  input  32  rt value written on store
write_address_in  input  5  destination register
memory_read  input  1  load
memory_write  input  1  store
memory_to_register  input  1  select load data for write-back
register_write_in  input  1  instruction writes a register
stall  output  1  upstream must hold; inputs ignored while high
wb_valid  output  1  MEM/WB bundle valid (one-cycle pulse per instruction)
write_data  output  32  write-back data
write_address  output  5  write-back register
register_write  output  1  GPR write enable (qualified by wb_valid)
misaligned_fault  output  1  pulses with wb_valid on misaligned memory op

Behaviour:
- Clocking and reset: one clock (system_clock); reset is synchronous and active-high.
- Reset values: stall, wb_valid, register_write and misaligned_fault = 0; write_data = 0; write_address = 0; FSM = IDLE; counter = 0.
- Memory contents are not reset.
- Accept: bundle sampled at a rising edge when ex_valid=1 and stall=0. Inputs are ignored while stall=1.
- FSM states: IDLE, ACCESS.
- stall = (state == ACCESS). It is derived from registered state only, with no combinational path from inputs.
- Non-memory op (memory_read = memory_write = 0):
  - Latency 1: wb_valid=1 in the cycle after the accept edge.
  - write_data = alu_result, write_address = write_address_in, register_write = register_write_in.
- Misaligned memory op (alu_result[1:0] != 0):
  - No memory access; latency 1.
  - misaligned_fault=1 with wb_valid; register_write=0; write_data = alu_result.
- Aligned memory op, MEMORY_LATENCY = 1: access performed at the accept edge; results follow the non-memory timing, with no stall.
- Aligned memory op, MEMORY_LATENCY = L > 1:
  - Accept edge latches the bundle; state goes to ACCESS; counter = L-1.
  - Each subsequent edge decrements the counter.
  - At the edge where counter == 1, the access is performed, state returns to IDLE and MEM/WB is updated.
  - stall is high for exactly L-1 cycles; wb_valid is high in the cycle after the L-th edge counted from accept.
- Word index is alu_result[ADDRESS_WIDTH+1:2]; upper address bits are ignored (wrap modulo depth).
- Store: the memory write happens only at the completion edge. wb_valid pulses with register_write=0; write_data = alu_result.
- Load: write_data = mem[index] if memory_to_register=1, else alu_result. register_write = latched register_write_in.
- memory_read and memory_write both 1: treated as a store; no load data; register_write=0.
- Read-after-write: a load accepted after a store's completion returns the new data.
- Idle cycles: wb_valid, register_write and misaligned_fault are 0; write_data and write_address hold their last values.
- Reset during ACCESS: the access is aborted with no memory write. The FSM returns to IDLE and all outputs take reset values in the next cycle.
- Back-to-back: with L=1 a new bundle may be accepted every cycle. With L>1 the next accept is possible on the cycle stall falls, i.e. in the same cycle wb_valid is high.

Test Plan:
- Reset, then ALU op alu_result=0x0000_1234, write_address_in=8, register_write_in=1 -> next cycle wb_valid=1, write_data=0x1234, write_address=8, register_write=1, stall=0 throughout.
- L=2: store 0xDEADBEEF at 0x10, then load from 0x10 with memory_to_register=1, write_address_in=3:
  - stall high 1 cycle per op.
  - store pulse has register_write=0.
  - load pulse has write_data=0xDEADBEEF, write_address=3, register_write=1.
- Load at 0x0000_0013 -> 1-cycle latency, misaligned_fault=1, register_write=0, memory unchanged (a subsequent aligned load from 0x10 still returns 0xDEADBEEF).
- ADDRESS_WIDTH=10: store 0x11111111 to 0x1000 (wraps to index 0); load from 0x0000 -> 0x11111111.
- L=4: assert reset while store to 0x20 is in ACCESS (2nd stall cycle) -> next cycle all outputs 0; later load from 0x20 does not return the aborted store data.
- L=3: hold ex_valid=1 with changing inputs during stall -> changes ignored; exactly one wb_valid pulse per accepted bundle, carrying the accept-edge values.

Source files
------------

// File: rtl/memory_access_stage_if.sv
// EX/MEM input bundle and MEM/WB output bundle of the memory access stage.
interface memory_access_stage_if;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  write_address_in;
    logic        memory_read;
    logic        memory_write;
    logic        memory_to_register;
    logic        register_write_in;
    logic        stall;
    logic        wb_valid;
    logic [31:0] write_data;
    logic [4:0]  write_address;
    logic        register_write;
    logic        misaligned_fault;

    modport master (
        output ex_valid, alu_result, store_data, write_address_in,
        output memory_read, memory_write, memory_to_register,
        output register_write_in,
        input  stall, wb_valid, write_data, write_address,
        input  register_write, misaligned_fault
    );

    modport slave (
        input  ex_valid, alu_result, store_data, write_address_in,
        input  memory_read, memory_write, memory_to_register,
        input  register_write_in,
        output stall, wb_valid, write_data, write_address,
        output register_write, misaligned_fault
    );
endinterface

// File: rtl/memory_access_stage.sv
// MEM stage: word load/store into internal data memory with configurable
// latency, registered MEM/WB bundle and upstream stall.
module memory_access_stage #(
    parameter int ADDRESS_WIDTH  = 10,
    parameter int MEMORY_LATENCY = 2
) (
    input logic                  system_clock,
    input logic                  reset,
    memory_access_stage_if.slave bus
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int CW = (MEMORY_LATENCY > 1) ? $clog2(MEMORY_LATENCY) : 1;
    localparam bit MULTI = (MEMORY_LATENCY > 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   count, count_n;
    logic            latch_en;
    logic            done;

    logic [31:0]     lat_addr, lat_data;
    logic [4:0]      lat_wa;
    logic            lat_rd, lat_wr, lat_m2r, lat_rw;

    logic [31:0]     sel_addr, sel_data;
    logic [4:0]      sel_wa;
    logic            sel_rd, sel_wr, sel_m2r, sel_rw;
    logic            sel_mis, is_load, mem_we;
    logic [31:0]     wd;
    logic            rw;
    logic [ADDRESS_WIDTH-1:0] idx;
    logic            in_mem, in_long;

    logic [31:0]     mem [DEPTH];

    assign bus.stall = (state == ACCESS);

    assign in_mem  = bus.memory_read | bus.memory_write;
    assign in_long = MULTI && in_mem && (bus.alu_result[1:0] == 2'b00);

    always_comb begin
        state_n  = state;
        count_n  = count;
        latch_en = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ex_valid) begin
                    if (in_long) begin
                        state_n  = ACCESS;
                        count_n  = CW'(MEMORY_LATENCY - 1);
                        latch_en = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (count == CW'(1)) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end else begin
                    count_n = count - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Completion in ACCESS uses the bundle captured at accept; otherwise the live inputs.
    always_comb begin
        if (state == ACCESS) begin
            sel_addr = lat_addr;
            sel_data = lat_data;
            sel_wa   = lat_wa;
            sel_rd   = lat_rd;
            sel_wr   = lat_wr;
            sel_m2r  = lat_m2r;
            sel_rw   = lat_rw;
        end else begin
            sel_addr = bus.alu_result;
            sel_data = bus.store_data;
            sel_wa   = bus.write_address_in;
            sel_rd   = bus.memory_read;
            sel_wr   = bus.memory_write;
            sel_m2r  = bus.memory_to_register;
            sel_rw   = bus.register_write_in;
        end
    end

    assign idx     = sel_addr[ADDRESS_WIDTH+1:2];
    assign sel_mis = (sel_rd | sel_wr) && (sel_addr[1:0] != 2'b00);
    assign is_load = sel_rd & ~sel_wr & ~sel_mis;
    assign mem_we  = done & sel_wr & ~sel_mis & ~reset;
    assign wd      = (is_load & sel_m2r) ? mem[idx] : sel_addr;
    assign rw      = sel_rw & ~sel_mis & ~sel_wr;

    always_ff @(posedge system_clock) begin
        if (mem_we) begin
            mem[idx] <= sel_data;
        end
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state                <= IDLE;
            count                <= '0;
            bus.wb_valid         <= 1'b0;
            bus.write_data       <= '0;
            bus.write_address    <= '0;
            bus.register_write   <= 1'b0;
            bus.misaligned_fault <= 1'b0;
        end else begin
            state                <= state_n;
            count                <= count_n;
            bus.wb_valid         <= done;
            bus.register_write   <= done & rw;
            bus.misaligned_fault <= done & sel_mis;
            if (done) begin
                bus.write_data    <= wd;
                bus.write_address <= sel_wa;
            end
        end
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_wa   <= '0;
            lat_rd   <= 1'b0;
            lat_wr   <= 1'b0;
            lat_m2r  <= 1'b0;
            lat_rw   <= 1'b0;
        end else if (latch_en) begin
            lat_addr <= bus.alu_result;
            lat_data <= bus.store_data;
            lat_wa   <= bus.write_address_in;
            lat_rd   <= bus.memory_read;
            lat_wr   <= bus.memory_write;
            lat_m2r  <= bus.memory_to_register;
            lat_rw   <= bus.register_write_in;
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench: four stage instances (latency 1..4) sharing one driver,
// outputs of the selected instance observed through a mux.
module tb_memory_access_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int sel = 2;

    logic        drv_valid = 1'b0;
    logic [31:0] drv_addr = '0, drv_data = '0;
    logic [4:0]  drv_wa = '0;
    logic        drv_rd = 1'b0, drv_wr = 1'b0, drv_m2r = 1'b0, drv_rw = 1'b0;

    memory_access_stage_if bus1 ();
    memory_access_stage_if bus2 ();
    memory_access_stage_if bus3 ();
    memory_access_stage_if bus4 ();

    `define TB_DRIVE(B, N) \
        assign B.ex_valid = drv_valid && (sel == N); \
        assign B.alu_result = drv_addr; \
        assign B.store_data = drv_data; \
        assign B.write_address_in = drv_wa; \
        assign B.memory_read = drv_rd; \
        assign B.memory_write = drv_wr; \
        assign B.memory_to_register = drv_m2r; \
        assign B.register_write_in = drv_rw;

    `TB_DRIVE(bus1, 1)
    `TB_DRIVE(bus2, 2)
    `TB_DRIVE(bus3, 3)
    `TB_DRIVE(bus4, 4)

    memory_access_stage #(.ADDRESS_WIDTH(10), .MEMORY_LATENCY(1)) dut1 (
        .system_clock(clk), .reset(rst), .bus(bus1));
    memory_access_stage #(.ADDRESS_WIDTH(10), .MEMORY_LATENCY(2)) dut2 (
        .system_clock(clk), .reset(rst), .bus(bus2));
    memory_access_stage #(.ADDRESS_WIDTH(10), .MEMORY_LATENCY(3)) dut3 (
        .system_clock(clk), .reset(rst), .bus(bus3));
    memory_access_stage #(.ADDRESS_WIDTH(10), .MEMORY_LATENCY(4)) dut4 (
        .system_clock(clk), .reset(rst), .bus(bus4));

    logic        o_stall, o_wb, o_rw, o_mf;
    logic [31:0] o_wd;
    logic [4:0]  o_wa;

    always_comb begin
        o_stall = bus2.stall; o_wb = bus2.wb_valid; o_wd = bus2.write_data;
        o_wa = bus2.write_address; o_rw = bus2.register_write;
        o_mf = bus2.misaligned_fault;
        case (sel)
            1: begin
                o_stall = bus1.stall; o_wb = bus1.wb_valid; o_wd = bus1.write_data;
                o_wa = bus1.write_address; o_rw = bus1.register_write;
                o_mf = bus1.misaligned_fault;
            end
            3: begin
                o_stall = bus3.stall; o_wb = bus3.wb_valid; o_wd = bus3.write_data;
                o_wa = bus3.write_address; o_rw = bus3.register_write;
                o_mf = bus3.misaligned_fault;
            end
            4: begin
                o_stall = bus4.stall; o_wb = bus4.wb_valid; o_wd = bus4.write_data;
                o_wa = bus4.write_address; o_rw = bus4.register_write;
                o_mf = bus4.misaligned_fault;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] wa, input logic rd, input logic wr,
                         input logic m2r, input logic rw);
        drv_addr = a; drv_data = d; drv_wa = wa;
        drv_rd = rd; drv_wr = wr; drv_m2r = m2r; drv_rw = rw;
        drv_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] wa, input logic rd, input logic wr,
                        input logic m2r, input logic rw);
        drive(a, d, wa, rd, wr, m2r, rw);
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic wait_wb(input string tag, input int exp_stall);
        int n = 0;
        int s = 0;
        while (!o_wb && n < 20) begin
            if (o_stall) s++;
            @(negedge clk);
            n++;
        end
        check({tag, "_wb"}, o_wb, 1);
        check({tag, "_stallcyc"}, s, exp_stall);
        check({tag, "_stall_wb"}, o_stall, 0);
    endtask

    task automatic check_out(input string tag, input logic [31:0] wd,
                             input logic [4:0] wa, input logic rw,
                             input logic mf);
        check({tag, "_wd"}, o_wd, wd);
        check({tag, "_wa"}, o_wa, wa);
        check({tag, "_rw"}, o_rw, rw);
        check({tag, "_mf"}, o_mf, mf);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_stall"}, o_stall, 0);
        check({tag, "_wb"}, o_wb, 0);
        check_out(tag, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sel = 2; check_reset("rst2");
        sel = 4; check_reset("rst4");

        sel = 2;
        send(32'h0000_1234, 32'h0, 5'd8, 0, 0, 0, 1);
        wait_wb("alu", 0);
        check_out("alu", 32'h1234, 5'd8, 1'b1, 1'b0);

        send(32'h10, 32'hDEADBEEF, 5'd5, 0, 1, 0, 0);
        wait_wb("st10", 1);
        check_out("st10", 32'h10, 5'd5, 1'b0, 1'b0);
        send(32'h10, 32'h0, 5'd3, 1, 0, 1, 1);
        wait_wb("ld10", 1);
        check_out("ld10", 32'hDEADBEEF, 5'd3, 1'b1, 1'b0);

        send(32'h13, 32'h0, 5'd7, 1, 0, 1, 1);
        wait_wb("mis", 0);
        check_out("mis", 32'h13, 5'd7, 1'b0, 1'b1);
        @(negedge clk);
        check("idle_wb", o_wb, 0);
        check("idle_mf", o_mf, 0);
        check("idle_hold_wd", o_wd, 32'h13);
        check("idle_hold_wa", o_wa, 5'd7);
        send(32'h10, 32'h0, 5'd4, 1, 0, 1, 1);
        wait_wb("ld10b", 1);
        check_out("ld10b", 32'hDEADBEEF, 5'd4, 1'b1, 1'b0);

        send(32'h1000, 32'h11111111, 5'd0, 0, 1, 0, 0);
        wait_wb("stwrap", 1);
        send(32'h0, 32'h0, 5'd6, 1, 0, 1, 1);
        wait_wb("ldwrap", 1);
        check_out("ldwrap", 32'h11111111, 5'd6, 1'b1, 1'b0);

        send(32'h24, 32'h77, 5'd9, 1, 1, 1, 1);
        wait_wb("rdwr", 1);
        check_out("rdwr", 32'h24, 5'd9, 1'b0, 1'b0);
        send(32'h24, 32'h0, 5'd10, 1, 0, 1, 1);
        wait_wb("ld24", 1);
        check_out("ld24", 32'h77, 5'd10, 1'b1, 1'b0);

        send(32'h24, 32'h0, 5'd11, 1, 0, 0, 1);
        wait_wb("ldnom2r", 1);
        check_out("ldnom2r", 32'h24, 5'd11, 1'b1, 1'b0);

        sel = 4;
        @(negedge clk);
        send(32'h20, 32'h55555555, 5'd1, 0, 1, 0, 0);
        wait_wb("st20", 3);
        send(32'h20, 32'hCAFEF00D, 5'd1, 0, 1, 0, 0);
        @(negedge clk);
        check("abort_stall2", o_stall, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("abort");
        repeat (3) @(negedge clk);
        check("abort_nowb", o_wb, 0);
        send(32'h20, 32'h0, 5'd2, 1, 0, 1, 1);
        wait_wb("ld20", 3);
        check_out("ld20", 32'h55555555, 5'd2, 1'b1, 1'b0);

        sel = 3;
        @(negedge clk);
        send(32'h30, 32'h0BADF00D, 5'd0, 0, 1, 0, 0);
        wait_wb("st30", 2);
        drive(32'h30, 32'h0, 5'd12, 1, 0, 1, 1);
        @(posedge clk);
        @(negedge clk);
        drive(32'h99, 32'h0, 5'd20, 0, 0, 0, 1);
        check("hold_stall1", o_stall, 1);
        @(negedge clk);
        drive(32'h34, 32'h0, 5'd21, 0, 0, 0, 1);
        check("hold_stall2", o_stall, 1);
        check("hold_nowb", o_wb, 0);
        @(negedge clk);
        check("hold_wb", o_wb, 1);
        check_out("hold", 32'h0BADF00D, 5'd12, 1'b1, 1'b0);
        @(negedge clk);
        drv_valid = 1'b0;
        check("next_wb", o_wb, 1);
        check_out("next", 32'h34, 5'd21, 1'b1, 1'b0);
        @(negedge clk);
        check("next_end", o_wb, 0);

        sel = 1;
        @(negedge clk);
        send(32'h8, 32'h12345678, 5'd13, 0, 1, 0, 0);
        check("l1_st_stall", o_stall, 0);
        check("l1_st_wb", o_wb, 1);
        check_out("l1_st", 32'h8, 5'd13, 1'b0, 1'b0);
        send(32'h8, 32'h0, 5'd14, 1, 0, 1, 1);
        check("l1_ld_wb", o_wb, 1);
        check_out("l1_ld", 32'h12345678, 5'd14, 1'b1, 1'b0);
        send(32'h0000_0042, 32'h0, 5'd15, 0, 0, 0, 0);
        check("l1_alu_wb", o_wb, 1);
        check_out("l1_alu", 32'h42, 5'd15, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
